// File: rtl/register_file_if.sv
// Decode-side access bus for register_file: shared index, data and enables,
// plus the registered read data and scoreboard flag.
interface register_file_if #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 5
);
  logic [ADDR_WIDTH-1:0] index;
  logic [DATA_WIDTH-1:0] valueInput;
  logic                  readEnable;
  logic                  writeEnable;
  logic                  reserveEnable;
  logic [DATA_WIDTH-1:0] valueOutput;
  logic                  flagOutput;

  modport master (
    output index, valueInput, readEnable, writeEnable, reserveEnable,
    input  valueOutput, flagOutput
  );

  modport slave (
    input  index, valueInput, readEnable, writeEnable, reserveEnable,
    output valueOutput, flagOutput
  );
endinterface

// File: rtl/register_file.sv
// General-purpose register file with per-register valid (scoreboard) flags.
// Optional: define R0_HARDWIRED_EN to make register 0 read as constant 0/valid.
module register_file #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 5
) (
  input logic            clk,
  input logic            reset,
  register_file_if.slave bus
);
  localparam int unsigned DEPTH = 2 ** ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] regs [DEPTH];
  logic [DEPTH-1:0]      valid;
  logic [DATA_WIDTH-1:0] value_q;
  logic                  flag_q;

  logic                  r0_sel;
  logic                  wr_ok;
  logic                  rs_ok;
  logic [DATA_WIDTH-1:0] rd_value;
  logic                  rd_flag;

`ifdef R0_HARDWIRED_EN
  assign r0_sel = (bus.index == '0);
`else
  assign r0_sel = 1'b0;
`endif

  assign wr_ok = bus.writeEnable   && !r0_sel;
  assign rs_ok = bus.reserveEnable && !r0_sel;

  // Read path sees the post-edge state: write-first data, reserve beats write on the flag.
  always_comb begin
    rd_value = regs[bus.index];
    rd_flag  = valid[bus.index];
    if (wr_ok) begin
      rd_value = bus.valueInput;
      rd_flag  = 1'b1;
    end
    if (rs_ok) begin
      rd_flag = 1'b0;
    end
    if (r0_sel) begin
      rd_value = '0;
      rd_flag  = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      regs    <= '{default: '0};
      valid   <= '1;
      value_q <= '0;
      flag_q  <= 1'b1;
    end else begin
      if (wr_ok) begin
        regs[bus.index]  <= bus.valueInput;
        valid[bus.index] <= 1'b1;
      end
      if (rs_ok) begin
        valid[bus.index] <= 1'b0;
      end
      if (bus.readEnable) begin
        value_q <= rd_value;
        flag_q  <= rd_flag;
      end
    end
  end

  assign bus.valueOutput = value_q;
  assign bus.flagOutput  = flag_q;
endmodule

// File: tb/tb_register_file.sv
// Directed self-checking bench for register_file (default build or R0_HARDWIRED_EN).
module tb_register_file;
  logic clk;
  logic reset;
  int unsigned tests;
  int unsigned fails;

  register_file_if #(.DATA_WIDTH(32), .ADDR_WIDTH(5)) bus ();

  register_file #(.DATA_WIDTH(32), .ADDR_WIDTH(5)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic drive(input logic [4:0] idx, input logic [31:0] val,
                       input logic rd, input logic wr, input logic rs);
    bus.index         = idx;
    bus.valueInput    = val;
    bus.readEnable    = rd;
    bus.writeEnable   = wr;
    bus.reserveEnable = rs;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_out(input string tag, input logic [31:0] val, input logic flg);
    check({tag, ".val"}, bus.valueOutput, val);
    check({tag, ".flag"}, {31'd0, bus.flagOutput}, {31'd0, flg});
  endtask

  initial begin
    logic [31:0] r0_exp;
    logic [31:0] r0_byp;
    tests = 0;
    fails = 0;
    reset = 1'b1;
    drive(5'd0, 32'h0, 1'b0, 1'b0, 1'b0);
    tick();
    expect_out("reset", 32'h0, 1'b1);
    reset = 1'b0;

    drive(5'd7, 32'h0, 1'b1, 1'b0, 1'b0); tick();
    expect_out("rd7_after_reset", 32'h0, 1'b1);

    drive(5'd5, 32'hDEADBEEF, 1'b0, 1'b1, 1'b0); tick();
    drive(5'd5, 32'h0, 1'b1, 1'b0, 1'b0); tick();
    expect_out("wr_rd5", 32'hDEADBEEF, 1'b1);

    drive(5'd9, 32'h0, 1'b0, 1'b0, 1'b1); tick();
    drive(5'd9, 32'h0, 1'b1, 1'b0, 1'b0); tick();
    expect_out("reserved9", 32'h0, 1'b0);
    drive(5'd9, 32'h12345678, 1'b0, 1'b1, 1'b0); tick();
    drive(5'd9, 32'h0, 1'b1, 1'b0, 1'b0); tick();
    expect_out("rewritten9", 32'h12345678, 1'b1);

    drive(5'd3, 32'hA5A5A5A5, 1'b1, 1'b1, 1'b0); tick();
    expect_out("bypass3", 32'hA5A5A5A5, 1'b1);
    drive(5'd3, 32'h5A5A5A5A, 1'b1, 1'b1, 1'b1); tick();
    expect_out("bypass3_rsv", 32'h5A5A5A5A, 1'b0);
    drive(5'd3, 32'h0, 1'b1, 1'b0, 1'b0); tick();
    expect_out("rd3_after_wr_rsv", 32'h5A5A5A5A, 1'b0);

    drive(5'd5, 32'h0, 1'b1, 1'b0, 1'b1); tick();
    expect_out("rd_rsv5", 32'hDEADBEEF, 1'b0);

    drive(5'd5, 32'h11111111, 1'b0, 1'b1, 1'b0); tick();
    expect_out("hold_wr", 32'hDEADBEEF, 1'b0);
    drive(5'd9, 32'h0, 1'b0, 1'b0, 1'b1); tick();
    expect_out("hold_rsv", 32'hDEADBEEF, 1'b0);
    drive(5'd5, 32'h0, 1'b1, 1'b0, 1'b0); tick();
    expect_out("rd5_after_hold", 32'h11111111, 1'b1);

    drive(5'd31, 32'h80000001, 1'b0, 1'b1, 1'b0); tick();
    drive(5'd31, 32'h0, 1'b1, 1'b0, 1'b0); tick();
    expect_out("rd31", 32'h80000001, 1'b1);

`ifdef R0_HARDWIRED_EN
    r0_exp = 32'h00000000;
    r0_byp = 32'h00000000;
`else
    r0_exp = 32'hFFFFFFFF;
    r0_byp = 32'h00000077;
`endif
    drive(5'd0, 32'hFFFFFFFF, 1'b0, 1'b1, 1'b0); tick();
    drive(5'd0, 32'h0, 1'b1, 1'b0, 1'b0); tick();
    expect_out("rd0", r0_exp, 1'b1);
    drive(5'd0, 32'h00000077, 1'b1, 1'b1, 1'b0); tick();
    expect_out("bypass0", r0_byp, 1'b1);

    drive(5'd12, 32'h0, 1'b0, 1'b0, 1'b1); tick();
    reset = 1'b1;
    drive(5'd12, 32'h0000CAFE, 1'b1, 1'b1, 1'b0); tick();
    expect_out("reset_mid", 32'h0, 1'b1);
    reset = 1'b0;
    drive(5'd12, 32'h0, 1'b1, 1'b0, 1'b0); tick();
    expect_out("rd12_after_reset", 32'h0, 1'b1);
    drive(5'd3, 32'h0, 1'b1, 1'b0, 1'b0); tick();
    expect_out("rd3_after_reset", 32'h0, 1'b1);
    drive(5'd9, 32'h0, 1'b1, 1'b0, 1'b0); tick();
    expect_out("rd9_after_reset", 32'h0, 1'b1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
